// File: rtl/mxalu_pkg.sv
// rtl/mxalu_pkg.sv - shared types and constants for the mxalu8_seq ALU
//
// Contents:
//   opcode_e     4-bit operation codes ADD..SET
//   FLG_*        bit positions inside the packed status byte
//   rom_entry_t  function-generator control word {s[3:0], m, cn_n}
//   rom_lookup   16-entry opcode ROM
package mxalu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_INC  = 4'h2,
        OP_DEC  = 4'h3,
        OP_DBL  = 4'h4,
        OP_PSA  = 4'h5,
        OP_PSB  = 4'h6,
        OP_NOT  = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_XNOR = 4'hB,
        OP_NAND = 4'hC,
        OP_NOR  = 4'hD,
        OP_CLR  = 4'hE,
        OP_SET  = 4'hF
    } opcode_e;

    localparam int FLG_C   = 0;
    localparam int FLG_Z   = 1;
    localparam int FLG_N   = 2;
    localparam int FLG_V   = 3;
    localparam int FLG_H   = 4;
    localparam int FLG_P   = 5;
    localparam int FLG_AEB = 6;
    localparam int FLG_CI  = 7;

    typedef struct packed {
        logic [3:0] s;
        logic       m;
        logic       cn_n;
    } rom_entry_t;

    function automatic rom_entry_t rom_lookup(input opcode_e op);
        rom_entry_t r;
        case (op)
            OP_ADD:  r = '{s: 4'b1001, m: 1'b0, cn_n: 1'b1};
            OP_SUB:  r = '{s: 4'b0110, m: 1'b0, cn_n: 1'b0};
            OP_INC:  r = '{s: 4'b0000, m: 1'b0, cn_n: 1'b0};
            OP_DEC:  r = '{s: 4'b1111, m: 1'b0, cn_n: 1'b1};
            OP_DBL:  r = '{s: 4'b1100, m: 1'b0, cn_n: 1'b1};
            OP_PSA:  r = '{s: 4'b1111, m: 1'b1, cn_n: 1'b1};
            OP_PSB:  r = '{s: 4'b1010, m: 1'b1, cn_n: 1'b1};
            OP_NOT:  r = '{s: 4'b0000, m: 1'b1, cn_n: 1'b1};
            OP_AND:  r = '{s: 4'b1011, m: 1'b1, cn_n: 1'b1};
            OP_OR:   r = '{s: 4'b1110, m: 1'b1, cn_n: 1'b1};
            OP_XOR:  r = '{s: 4'b0110, m: 1'b1, cn_n: 1'b1};
            OP_XNOR: r = '{s: 4'b1001, m: 1'b1, cn_n: 1'b1};
            OP_NAND: r = '{s: 4'b0100, m: 1'b1, cn_n: 1'b1};
            OP_NOR:  r = '{s: 4'b0001, m: 1'b1, cn_n: 1'b1};
            OP_CLR:  r = '{s: 4'b0011, m: 1'b1, cn_n: 1'b1};
            default: r = '{s: 4'b1100, m: 1'b1, cn_n: 1'b1}; // OP_SET
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu181_slice.sv
// rtl/alu181_slice.sv - 4-bit 74181-style function generator slice
//
// Ports:
//   a, b     4-bit operands
//   s        function select
//   m        1 = logic mode (carries ignored in the result)
//   cn_n     active-low carry in
//   f        4-bit result
//   p_grp    slice propagate (active high, AND of bit propagates)
//   g_grp    slice generate (active high, carry out assuming carry in = 0)
//   cn4_n    active-low carry out
module alu181_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn_n,
    output logic [3:0] f,
    output logic       p_grp,
    output logic       g_grp,
    output logic       cn4_n
);

    logic [3:0] d;
    logic [3:0] e;
    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    always_comb begin
        d     = '0;
        e     = '0;
        p     = '0;
        g     = '0;
        c     = '0;
        f     = '0;
        g_grp = 1'b0;
        c[0]  = ~cn_n;
        for (int i = 0; i < 4; i++) begin
            d[i]     = ~(a[i] | (b[i] & s[0]) | (~b[i] & s[1]));
            e[i]     = ~((a[i] & ~b[i] & s[2]) | (a[i] & b[i] & s[3]));
            p[i]     = ~d[i];
            g[i]     = ~e[i];
            c[i+1]   = g[i] | (p[i] & c[i]);
            // m forces the carry term high, which turns the sum into a pure
            // bitwise function of e and d.
            f[i]     = e[i] ^ d[i] ^ (m | c[i]);
            g_grp    = g[i] | (p[i] & g_grp);
        end
    end

    assign p_grp = &p;
    assign cn4_n = ~c[4];

endmodule

// File: rtl/mxalu8_seq.sv
// rtl/mxalu8_seq.sv - 8-bit registered ALU built from cascaded 74181-style slices
//
// Optional feature macro: MXALU_PARITY_EN (defined: flags[5] is even parity
// of the result; undefined: flags[5] is tied to 0).
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   cs_n     active-low chip select; 1 holds all output registers
//   opcode   operation select (mxalu_pkg::opcode_e)
//   a, b     operands
//   f        registered result
//   x        registered group propagate, active low
//   y        registered group generate, active low
//   flags    registered status byte {CI,AEB,P,H,V,N,Z,C}
module mxalu8_seq
    import mxalu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] f,
    output logic             x,
    output logic             y,
    output logic [7:0]       flags
);

    localparam int NS = WIDTH / 4;

    opcode_e          op;
    rom_entry_t       rom;
    logic [NS:0]      cn_chain;
    logic [NS-1:0]    p_grp;
    logic [NS-1:0]    g_grp;
    logic [WIDTH-1:0] f_core;
    logic             p_all;
    logic             g_all;
    logic             ovf;
    logic             parity;
    logic [7:0]       flags_next;

    assign op          = opcode_e'(opcode);
    assign rom         = rom_lookup(op);
    assign cn_chain[0] = rom.cn_n;

    for (genvar k = 0; k < NS; k++) begin : g_slice
        alu181_slice u_slice (
            .a     (a[4*k +: 4]),
            .b     (b[4*k +: 4]),
            .s     (rom.s),
            .m     (rom.m),
            .cn_n  (cn_chain[k]),
            .f     (f_core[4*k +: 4]),
            .p_grp (p_grp[k]),
            .g_grp (g_grp[k]),
            .cn4_n (cn_chain[k+1])
        );
    end

    // Group lookahead across slices; y reflects generate only, independent
    // of the carry in.
    always_comb begin
        p_all = 1'b1;
        g_all = 1'b0;
        for (int k = 0; k < NS; k++) begin
            g_all = g_grp[k] | (p_grp[k] & g_all);
            p_all = p_all & p_grp[k];
        end
    end

    always_comb begin
        ovf = 1'b0;
        if (!rom.m) begin
            case (op)
                OP_ADD:  ovf = (a[WIDTH-1] == b[WIDTH-1]) && (f_core[WIDTH-1] != a[WIDTH-1]);
                OP_SUB:  ovf = (a[WIDTH-1] != b[WIDTH-1]) && (f_core[WIDTH-1] != a[WIDTH-1]);
                OP_INC:  ovf = (a == {1'b0, {(WIDTH-1){1'b1}}});
                OP_DEC:  ovf = (a == {1'b1, {(WIDTH-1){1'b0}}});
                OP_DBL:  ovf = (a[WIDTH-1] != a[WIDTH-2]);
                default: ovf = 1'b0;
            endcase
        end
    end

`ifdef MXALU_PARITY_EN
    assign parity = ~^f_core;
`else
    assign parity = 1'b0;
`endif

    always_comb begin
        flags_next          = '0;
        flags_next[FLG_C]   = ~rom.m & ~cn_chain[NS];
        flags_next[FLG_Z]   = (f_core == '0);
        flags_next[FLG_N]   = f_core[WIDTH-1];
        flags_next[FLG_V]   = ovf;
        flags_next[FLG_H]   = ~rom.m & ~cn_chain[1];
        flags_next[FLG_P]   = parity;
        flags_next[FLG_AEB] = &f_core;
        flags_next[FLG_CI]  = ~rom.cn_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f     <= '0;
            x     <= 1'b1;
            y     <= 1'b1;
            flags <= '0;
        end else if (!cs_n) begin
            f     <= f_core;
            x     <= ~p_all;
            y     <= ~g_all;
            flags <= flags_next;
        end
    end

endmodule

// File: tb/tb_mxalu8_seq.sv
// tb/tb_mxalu8_seq.sv - directed table-driven bench for mxalu8_seq
module tb_mxalu8_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] f;
    logic       x;
    logic       y;
    logic [7:0] flags;

    int n_total = 0;
    int n_pass  = 0;

`ifdef MXALU_PARITY_EN
    localparam logic [7:0] PMASK = 8'hFF;
`else
    localparam logic [7:0] PMASK = 8'hDF;
`endif

    mxalu8_seq dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cs_n   (cs_n),
        .opcode (opcode),
        .a      (a),
        .b      (b),
        .f      (f),
        .x      (x),
        .y      (y),
        .flags  (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] f;
        logic       x;
        logic       y;
        logic [7:0] flags;
    } vec_t;

    vec_t vec[18];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic check_out(input string tag, input logic [7:0] ef, input logic ex,
                             input logic ey, input logic [7:0] efl);
        chk({tag, ".f"}, f, ef);
        chk({tag, ".x"}, {7'b0, x}, {7'b0, ex});
        chk({tag, ".y"}, {7'b0, y}, {7'b0, ey});
        chk({tag, ".flags"}, flags, efl & PMASK);
    endtask

    initial begin
        //          op     a      b      f      x     y     flags
        vec[0]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b1, 8'h1C}; // ADD overflow
        vec[1]  = '{4'h1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 8'hB3}; // SUB equal
        vec[2]  = '{4'hA, 8'hF0, 8'hFF, 8'h0F, 1'b1, 1'b1, 8'h20}; // XOR
        vec[3]  = '{4'hF, 8'hF0, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h64}; // SET
        vec[4]  = '{4'h2, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 8'hB3}; // INC wrap
        vec[5]  = '{4'h3, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1, 8'h64}; // DEC wrap
        vec[6]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 8'h33}; // ADD wrap
        vec[7]  = '{4'h1, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b1, 8'hE4}; // SUB borrow
        vec[8]  = '{4'h1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 8'h89}; // SUB overflow
        vec[9]  = '{4'h2, 8'h7F, 8'h00, 8'h80, 1'b1, 1'b1, 8'h9C}; // INC overflow
        vec[10] = '{4'h3, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 8'h09}; // DEC overflow
        vec[11] = '{4'h4, 8'hC0, 8'h00, 8'h80, 1'b1, 1'b0, 8'h05}; // DBL carry
        vec[12] = '{4'h4, 8'h40, 8'h00, 8'h80, 1'b1, 1'b1, 8'h0C}; // DBL overflow
        vec[13] = '{4'h8, 8'h3C, 8'h0F, 8'h0C, 1'b0, 1'b0, 8'h20}; // AND
        vec[14] = '{4'h9, 8'h3C, 8'h0F, 8'h3F, 1'b1, 1'b0, 8'h20}; // OR
        vec[15] = '{4'hD, 8'h3C, 8'h0F, 8'hC0, 1'b1, 1'b1, 8'h24}; // NOR
        vec[16] = '{4'h6, 8'h55, 8'h00, 8'h00, 1'b0, 1'b1, 8'h22}; // PSB
        vec[17] = '{4'hE, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1, 8'h22}; // CLR

        rst_n  = 1'b0;
        cs_n   = 1'b1;
        opcode = 4'h0;
        a      = 8'h00;
        b      = 8'h00;
        repeat (2) @(negedge clk);
        check_out("reset", 8'h00, 1'b1, 1'b1, 8'h00);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            cs_n   = 1'b0;
            opcode = vec[i].op;
            a      = vec[i].a;
            b      = vec[i].b;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d_op%0h", i, vec[i].op),
                      vec[i].f, vec[i].x, vec[i].y, vec[i].flags);
        end

        // Chip select high: registers hold while every input moves.
        @(negedge clk);
        cs_n = 1'b0; opcode = 4'hF; a = 8'hF0; b = 8'hFF;
        @(posedge clk);
        #1;
        check_out("hold_load", 8'hFF, 1'b1, 1'b0, 8'h64);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cs_n   = 1'b1;
            opcode = 4'(i);
            a      = 8'(8'h11 * (i + 1));
            b      = 8'(8'h07 + i);
            @(posedge clk);
            #1;
            check_out($sformatf("hold%0d", i), 8'hFF, 1'b1, 1'b0, 8'h64);
        end

        // Asynchronous reset mid-cycle, then a normal load after release.
        @(negedge clk);
        cs_n = 1'b0; opcode = 4'h0; a = 8'h7F; b = 8'h01;
        @(posedge clk);
        #1;
        check_out("pre_rst", 8'h80, 1'b1, 1'b1, 8'h1C);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 8'h00, 1'b1, 1'b1, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 4'h1; a = 8'h05; b = 8'h05;
        @(posedge clk);
        #1;
        check_out("post_rst", 8'h00, 1'b0, 1'b1, 8'hB3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mxalu8_seq.md
Name: mxalu8_seq

Overview:
- 8-bit unsigned ALU with registered outputs. Internally it is a 74181-style function generator: two cascaded 4-bit slices with ripple carry.
- A 16-entry opcode ROM maps the 4-bit opcode to select S[3:0], mode M and active-low carry-in cn_n.
- A flag generator packs the status into one byte.
- Sits between the register file and the accumulator/flag register of the MX 1-byte datapath.

Parameters:
- WIDTH, 8, data width; fixed at 8 and must be a multiple of 4.

Ports:
- clk  input  1  system clock; all state changes on its rising edge
- rst_n  input  1  asynchronous active-low reset
- cs_n  input  1  active-low chip select; 1 = hold all outputs
- opcode  input  4  operation select (see Behaviour)
- a  input  8  operand A
- b  input  8  operand B
- f  output  8  registered result
- x  output  1  registered group propagate, active-low
- y  output  1  registered group generate, active-low
- flags  output  8  registered status byte

Behaviour:
- Reset: f=0x00, x=1, y=1, flags=0x00. Reset is asynchronous, applied immediately, and overrides any operation in progress.
- Latency: 1 cycle. Inputs sampled at a clk rise with cs_n=0 appear on the outputs after that edge. With cs_n=1 all registers hold.
- ROM (opcode -> S,M,cn_n):
  - 0 ADD 1001,0,1 -> a+b
  - 1 SUB 0110,0,0 -> a-b
  - 2 INC 0000,0,0 -> a+1
  - 3 DEC 1111,0,1 -> a-1
  - 4 DBL 1100,0,1 -> a+a
  - 5 PSA 1111,1,1 -> a
  - 6 PSB 1010,1,1 -> b
  - 7 NOT 0000,1,1 -> ~a
  - 8 AND 1011,1,1
  - 9 OR 1110,1,1
  - A XOR 0110,1,1
  - B XNOR 1001,1,1
  - C NAND 0100,1,1
  - D NOR 0001,1,1
  - E CLR 0011,1,1 -> 0x00
  - F SET 1100,1,1 -> 0xFF
- Per-bit core equations (i=0..7):
  - D_i = ~(a_i | b_i&S0 | ~b_i&S1)
  - E_i = ~(a_i&~b_i&S2 | a_i&b_i&S3)
  - g_i = ~E_i, p_i = ~D_i
  - c_0 = ~cn_n, c_(i+1) = g_i | p_i&c_i
  - f_i = E_i ^ D_i ^ (M | c_i)
- Core outputs:
  - cn4_n = ~c_4, cn8_n = ~c_8
  - x = ~&p[7:0]
  - y = ~(8-bit carry-lookahead generate over g/p)
  - a_b = &f
- flags bit map:
  - 0 C = ~cn8_n; on SUB this is 1 = no borrow
  - 1 Z = (f==0)
  - 2 N = f[7]
  - 3 V = signed overflow; 0 in logic ops. ADD: a7==b7 && f7!=a7. SUB: a7!=b7 && f7!=a7. INC: a==0x7F. DEC: a==0x80. DBL: a7!=a6.
  - 4 H = ~cn4_n
  - 5 P = ~^f, even parity
  - 6 AEB = a_b
  - 7 CI = ~cn_n
- In logic mode (M=1), flags C, H and V are forced to 0.
- Wrap-around is modulo 256: 0xFF+1 = 0x00 with C=1; 0x00-1 = 0xFF with C=0.

Optional Feature:
- MXALU_PARITY_EN defined: flags[5] = ~^f as specified.
- Undefined: flags[5] is tied to 0 and no parity logic is synthesised.

Decomposition:
- Package mxalu_pkg holds:
  - opcode enum (ADD..SET)
  - flag bit-index constants (FLG_C..FLG_CI)
  - a packed struct {S[3:0], M, cn_n} for ROM entries
- One sub-module: alu181_slice, a 4-bit slice exposing f, per-slice P/G and carry-out. It is instantiated twice and cascaded.
- The ROM, the flag logic and the output registers live in the top level.

Test Plan:
- ADD a=0x7F b=0x01 -> next cycle f=0x80, flags=0x1C (N,V,H).
- SUB a=0x05 b=0x05 -> f=0x00, flags=0xB3 (C,Z,H,P,CI).
- XOR a=0xF0 b=0xFF -> f=0x0F, flags=0x20. SET -> f=0xFF, flags=0x64 (N,P,AEB).
- INC a=0xFF -> f=0x00, flags=0xB3 (C,Z,H,P,CI). DEC a=0x00 -> f=0xFF, flags=0x64 (N,P,AEB).
- cs_n=1 while a, b and opcode change for 3 cycles -> f, x, y, flags unchanged.
- rst_n low mid-cycle during ADD -> outputs immediately f=0x00, flags=0x00, x=y=1. After release, the first cs_n=0 edge loads normally.
